// File: rtl/i2c_xfer_seq_if.sv
// i2c_xfer_seq_if
//   Bundles the request/response channel and the byte-controller command channel of the
//   I2C register-transaction sequencer.
//   master : sequencer view. It takes requests plus dout/cmd_ack/rx_ack from the byte
//            controller, and drives req_ready, the response, busy and the command strobes.
//   slave  : environment view (requester plus byte controller), the mirror image.
interface i2c_xfer_seq_if #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned REG_ADDR_BYTES = 1,
    parameter int unsigned MAX_BYTES      = 4
);
    localparam int unsigned LenW = $clog2(MAX_BYTES + 1);

    logic                            req_valid_i;
    logic                            req_ready_o;
    logic                            req_rnw_i;
    logic [6:0]                      req_dev_addr_i;
    logic [8*REG_ADDR_BYTES-1:0]     req_reg_addr_i;
    logic [LenW-1:0]                 req_len_i;
    logic [DATA_WIDTH*MAX_BYTES-1:0] req_wdata_i;
    logic                            rsp_valid_o;
    logic                            rsp_err_o;
    logic [DATA_WIDTH*MAX_BYTES-1:0] rsp_rdata_o;
    logic                            busy_o;
    logic                            start_o;
    logic                            stop_o;
    logic                            read_o;
    logic                            write_o;
    logic                            ack_in_o;
    logic [DATA_WIDTH-1:0]           din_o;
    logic [DATA_WIDTH-1:0]           dout_i;
    logic                            cmd_ack_i;
    logic                            rx_ack_i;

    modport master (
        input  req_valid_i, req_rnw_i, req_dev_addr_i, req_reg_addr_i, req_len_i, req_wdata_i,
        input  dout_i, cmd_ack_i, rx_ack_i,
        output req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, busy_o,
        output start_o, stop_o, read_o, write_o, ack_in_o, din_o
    );

    modport slave (
        output req_valid_i, req_rnw_i, req_dev_addr_i, req_reg_addr_i, req_len_i, req_wdata_i,
        output dout_i, cmd_ack_i, rx_ack_i,
        input  req_ready_o, rsp_valid_o, rsp_err_o, rsp_rdata_o, busy_o,
        input  start_o, stop_o, read_o, write_o, ack_in_o, din_o
    );
endinterface

// File: rtl/i2c_xfer_seq.sv
// i2c_xfer_seq
//   Expands one I2C register read/write request into the byte-level command stream of an
//   I2C byte controller, and returns a one-cycle response with error flag and read data.
//   Ports:
//     clk_i   - clock
//     arstn_i - asynchronous active-low reset
//     bus     - i2c_xfer_seq_if.master: request/response channel and command channel
//   Optional feature: define I2C_SEQ_RETRY_EN to restart a NACKed transaction from its
//   first command, up to MAX_RETRY times.
module i2c_xfer_seq #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned REG_ADDR_BYTES = 1,
    parameter int unsigned MAX_BYTES      = 4,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic           clk_i,
    input  logic           arstn_i,
    i2c_xfer_seq_if.master bus
);
    localparam int unsigned LenW = $clog2(MAX_BYTES + 1);
    // Worst case command count: address, reg bytes, repeated-start address, data bytes.
    localparam int unsigned IdxW = $clog2(REG_ADDR_BYTES + MAX_BYTES + 2);

    typedef enum logic [2:0] {StIdle, StCmd, StGap, StAbort, StResp} state_e;

    state_e                          state_q, state_d;
    logic [IdxW-1:0]                 idx_q, idx_d;
    logic                            rnw_q;
    logic [6:0]                      dev_q;
    logic [8*REG_ADDR_BYTES-1:0]     reg_q;
    logic [LenW-1:0]                 len_q;
    logic [DATA_WIDTH*MAX_BYTES-1:0] wdata_q;
    logic [DATA_WIDTH*MAX_BYTES-1:0] rdata_q, rdata_d;
    logic [DATA_WIDTH*MAX_BYTES-1:0] rsp_rdata_q;
    logic                            rsp_err_q, rsp_err_d;
    logic                            accept, rd_capture, rsp_load, retry_ok;
    logic [LenW-1:0]                 len_clamped;
    logic [IdxW-1:0]                 last_idx;
    logic                            cmd_last;
    logic                            c_start, c_write, c_read, c_ack_in;
    logic [DATA_WIDTH-1:0]           c_din;

    assign len_clamped = (bus.req_len_i > LenW'(MAX_BYTES)) ? LenW'(MAX_BYTES) : bus.req_len_i;
    // Reads carry one extra command: the repeated-start address byte.
    assign last_idx = rnw_q ? IdxW'(REG_ADDR_BYTES + 1) + IdxW'(len_q)
                            : IdxW'(REG_ADDR_BYTES) + IdxW'(len_q);
    assign cmd_last = (idx_q == last_idx);

    // Command at position idx_q of the current transaction.
    always_comb begin
        c_start  = 1'b0;
        c_write  = 1'b0;
        c_read   = 1'b0;
        c_ack_in = 1'b0;
        c_din    = '0;
        if (idx_q == '0) begin
            c_start = 1'b1;
            c_write = 1'b1;
            c_din   = DATA_WIDTH'({dev_q, 1'b0});
        end else if (idx_q <= IdxW'(REG_ADDR_BYTES)) begin
            c_write = 1'b1;
            for (int i = 0; i < int'(REG_ADDR_BYTES); i++) begin
                // Register address goes MSB first: idx 1 carries the top byte.
                if (int'(idx_q) == int'(REG_ADDR_BYTES) - i) c_din = DATA_WIDTH'(reg_q[8*i +: 8]);
            end
        end else if (!rnw_q) begin
            c_write = 1'b1;
            for (int i = 0; i < int'(MAX_BYTES); i++) begin
                if (int'(idx_q) == int'(REG_ADDR_BYTES) + 1 + i) begin
                    c_din = wdata_q[DATA_WIDTH*i +: DATA_WIDTH];
                end
            end
        end else if (int'(idx_q) == int'(REG_ADDR_BYTES) + 1) begin
            c_start = 1'b1;
            c_write = 1'b1;
            c_din   = DATA_WIDTH'({dev_q, 1'b1});
        end else begin
            c_read   = 1'b1;
            c_ack_in = cmd_last;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        accept     = 1'b0;
        rd_capture = 1'b0;
        rsp_load   = 1'b0;
        rsp_err_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (bus.req_valid_i) begin
                    accept = 1'b1;
                    idx_d  = '0;
                    if (bus.req_rnw_i && len_clamped == '0) begin
                        state_d   = StResp;
                        rsp_load  = 1'b1;
                        rsp_err_d = 1'b1;
                    end else begin
                        state_d = StCmd;
                    end
                end
            end
            StCmd: begin
                if (bus.cmd_ack_i) begin
                    rd_capture = c_read;
                    if (c_write && bus.rx_ack_i) begin
                        if (cmd_last) begin
                            // STOP already on the bus with this byte: no separate abort.
                            state_d   = StResp;
                            rsp_load  = 1'b1;
                            rsp_err_d = 1'b1;
                        end else begin
                            state_d = StAbort;
                        end
                    end else if (cmd_last) begin
                        state_d  = StResp;
                        rsp_load = 1'b1;
                    end else begin
                        state_d = StGap;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            StGap: state_d = StCmd;
            StAbort: begin
                if (bus.cmd_ack_i) begin
                    if (retry_ok) begin
                        state_d = StGap;
                        idx_d   = '0;
                    end else begin
                        state_d   = StResp;
                        rsp_load  = 1'b1;
                        rsp_err_d = 1'b1;
                    end
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (accept) begin
            rdata_d = '0;
        end else if (rd_capture) begin
            for (int i = 0; i < int'(MAX_BYTES); i++) begin
                if (int'(idx_q) == int'(REG_ADDR_BYTES) + 2 + i) begin
                    rdata_d[DATA_WIDTH*i +: DATA_WIDTH] = bus.dout_i;
                end
            end
        end
    end

`ifdef I2C_SEQ_RETRY_EN
    localparam int unsigned RetryW = $clog2(MAX_RETRY + 2);
    logic [RetryW-1:0] retry_q;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            retry_q <= '0;
        end else if (accept) begin
            retry_q <= '0;
        end else if (state_q == StAbort && bus.cmd_ack_i && retry_ok) begin
            retry_q <= retry_q + 1'b1;
        end
    end

    assign retry_ok = (retry_q < RetryW'(MAX_RETRY));
`else
    assign retry_ok = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            rnw_q       <= 1'b0;
            dev_q       <= '0;
            reg_q       <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rdata_q <= rdata_d;
            if (accept) begin
                rnw_q   <= bus.req_rnw_i;
                dev_q   <= bus.req_dev_addr_i;
                reg_q   <= bus.req_reg_addr_i;
                len_q   <= len_clamped;
                wdata_q <= bus.req_wdata_i;
            end
            if (rsp_load) begin
                rsp_rdata_q <= rdata_d;
                rsp_err_q   <= rsp_err_d;
            end
        end
    end

    // Strobes are decoded from state so an asynchronous reset drops them at once.
    always_comb begin
        bus.start_o  = 1'b0;
        bus.stop_o   = 1'b0;
        bus.read_o   = 1'b0;
        bus.write_o  = 1'b0;
        bus.ack_in_o = 1'b0;
        bus.din_o    = '0;
        if (state_q == StCmd) begin
            bus.start_o  = c_start;
            bus.stop_o   = cmd_last;
            bus.read_o   = c_read;
            bus.write_o  = c_write;
            bus.ack_in_o = c_ack_in;
            bus.din_o    = c_din;
        end else if (state_q == StAbort) begin
            bus.stop_o = 1'b1;
        end
    end

    assign bus.req_ready_o = (state_q == StIdle);
    assign bus.busy_o      = (state_q != StIdle);
    assign bus.rsp_valid_o = (state_q == StResp);
    assign bus.rsp_err_o   = rsp_err_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
endmodule
